ser_par_conv: RTL and testbench

//  Serial-to-parallel converter loading a signed threshold word ("soglia") one bit per clock.

---
 rtl/ser_par_pkg.sv | 8 +
 rtl/ser_par_bitcnt.sv | 34 +++
 rtl/ser_par_conv.sv | 41 ++++
 tb/tb_ser_par_conv.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/ser_par_pkg.sv
// Shared definitions for the detector threshold serial-to-parallel converter.
package ser_par_pkg;

  localparam int unsigned SOGLIA_W = 12;

  typedef logic signed [SOGLIA_W-1:0] soglia_t;

endpackage

// File: rtl/ser_par_bitcnt.sv
// Word-boundary counter: pulses done for one cycle after the edge completing each WIDTH-bit word.
module ser_par_bitcnt
  import ser_par_pkg::*;
#(
  parameter int unsigned WIDTH = SOGLIA_W
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic done
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic [CW-1:0] cnt;
  logic          wrap;

  always_comb begin
    wrap = en && (cnt == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt  <= '0;
      done <= 1'b0;
    end else begin
      done <= wrap;
      if (en) begin
        cnt <= wrap ? '0 : cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ser_par_conv.sv
// Serial-to-parallel threshold loader, MSB first; soglia is the live shift register.
// Define SER_PAR_VALID_EN to add the soglia_valid word-complete pulse.
module ser_par_conv
  import ser_par_pkg::*;
#(
  parameter int unsigned WIDTH = SOGLIA_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    din,
`ifdef SER_PAR_VALID_EN
  output logic                    soglia_valid,
`endif
  output logic signed [WIDTH-1:0] soglia
);

  if (WIDTH < 2) begin : g_width_check
    $error("ser_par_conv: WIDTH must be >= 2");
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      soglia <= '0;
    end else if (enable) begin
      soglia <= {soglia[WIDTH-2:0], din};
    end
  end

`ifdef SER_PAR_VALID_EN
  ser_par_bitcnt #(
    .WIDTH(WIDTH)
  ) u_bitcnt (
    .clk (clk),
    .rst (rst),
    .en  (enable),
    .done(soglia_valid)
  );
`endif

endmodule

// File: tb/tb_ser_par_conv.sv
// Self-checking bench for ser_par_conv: vector table, hand sequences and random stimulus vs a queue model.
module tb_ser_par_conv;
  import ser_par_pkg::*;

  localparam int unsigned W = SOGLIA_W;

  logic    clk = 1'b0;
  logic    rst = 1'b0;
  logic    enable = 1'b0;
  logic    din = 1'b0;
  soglia_t soglia;
  logic    soglia_valid;

  always #5 clk = ~clk;

  ser_par_conv #(
    .WIDTH(W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .din         (din),
`ifdef SER_PAR_VALID_EN
    .soglia_valid(soglia_valid),
`endif
    .soglia      (soglia)
  );

`ifndef SER_PAR_VALID_EN
  assign soglia_valid = 1'b0;
`endif

  int checks = 0;
  int failures = 0;

  // Reference: the last W received bits, plus enabled-edge count since reset.
  bit q[$];
  int edges = 0;
  int pulses = 0;

  typedef struct {
    logic    en;
    logic    din;
    soglia_t exp;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic logic [31:0] model_value();
    logic [31:0] v = 0;
    foreach (q[i]) v = v * 2 + q[i];
    return v;
  endfunction

  task automatic model_clear();
    q.delete();
    edges = 0;
  endtask

  // One clock: inputs are applied away from the edge, outputs sampled 1ns after it.
  task automatic step(input logic en_v, input logic din_v);
    logic exp_valid;
    enable = en_v;
    din    = din_v;
    @(posedge clk);
    exp_valid = 1'b0;
    if (en_v) begin
      q.push_back(din_v);
      if (q.size() > W) void'(q.pop_front());
      edges++;
      exp_valid = (edges % W) == 0;
    end
    #1;
    chk("soglia_model", {20'h0, soglia}, model_value());
`ifdef SER_PAR_VALID_EN
    chk("valid_model", {31'h0, soglia_valid}, {31'h0, exp_valid});
    if (soglia_valid) pulses++;
`endif
  endtask

  task automatic send_word(input logic [W-1:0] w);
    for (int unsigned i = 0; i < W; i++) step(1'b1, w[W-1-i]);
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic mid_reset();
    #2 rst = 1'b0;
    #1;
    chk("async_clear", {20'h0, soglia}, 32'h0);
    chk("async_valid", {31'h0, soglia_valid}, 32'h0);
    model_clear();
    #1 rst = 1'b1;
  endtask

  initial begin
    logic [W-1:0] w65d;
    logic [12:0]  w13;
    w65d = 12'h65D;
    w13  = {1'b1, 12'h65D};

    // Load 0x65D from zero, hold, then load all ones over it.
    begin
      soglia_t part [12] = '{12'h000, 12'h001, 12'h003, 12'h006, 12'h00C, 12'h019,
                             12'h032, 12'h065, 12'h0CB, 12'h197, 12'h32E, 12'h65D};
      soglia_t ones [12] = '{12'hCBB, 12'h977, 12'h2EF, 12'h5DF, 12'hBBF, 12'h77F,
                             12'hEFF, 12'hDFF, 12'hBFF, 12'h7FF, 12'hFFF, 12'hFFF};
      for (int unsigned i = 0; i < W; i++) tbl.push_back('{1'b1, w65d[W-1-i], part[i]});
      tbl.push_back('{1'b0, 1'b1, 12'h65D});
      for (int unsigned i = 0; i < W; i++) tbl.push_back('{1'b1, 1'b1, ones[i]});
      for (int unsigned i = 0; i < 10; i++) tbl.push_back('{1'b0, 1'b0, 12'hFFF});
    end

    // 1: reset state with enable low.
    repeat (2) @(posedge clk);
    #1;
    chk("reset_soglia", {20'h0, soglia}, 32'h0);
    chk("reset_valid", {31'h0, soglia_valid}, 32'h0);
    #3 rst = 1'b1;
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    chk("idle_after_reset", {20'h0, soglia}, 32'h0);

    // 2, 3: vector table.
    foreach (tbl[i]) begin
      step(tbl[i].en, tbl[i].din);
      chk($sformatf("tbl[%0d]", i), {20'h0, soglia}, {20'h0, tbl[i].exp});
    end
    chk("neg_one", 32'(int'(soglia)), 32'hFFFF_FFFF);

    // 4: thirteen bits {1, 0x65D}: the leading 1 falls out of the MSB.
    mid_reset();
    for (int unsigned i = 0; i < 13; i++) step(1'b1, w13[12-i]);
    chk("thirteen_bits", {20'h0, soglia}, 32'h65D);
    step(1'b1, 1'b0);
    chk("overflow_cba", {20'h0, soglia}, 32'hCBA);

    // 5: reset mid-load discards the partial word, then a full reload.
    mid_reset();
    for (int unsigned i = 0; i < 6; i++) step(1'b1, w65d[W-1-i]);
    mid_reset();
    send_word(w65d);
    chk("reload_after_reset", {20'h0, soglia}, 32'h65D);

    // 6: two back-to-back words then a gapped word; one pulse per word.
    mid_reset();
    pulses = 0;
    send_word(12'hA5C);
    send_word(12'h3F0);
    chk("b2b_word2", {20'h0, soglia}, 32'h3F0);
    for (int unsigned i = 0; i < W; i++) begin
      step(1'b1, w65d[W-1-i]);
      if (i % 3 == 1) step(1'b0, 1'b1);
    end
    step(1'b0, 1'b0);
    chk("gapped_word", {20'h0, soglia}, 32'h65D);
`ifdef SER_PAR_VALID_EN
    chk("pulse_count", pulses, 3);
`endif

    // Random traffic with occasional mid-cycle resets.
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 3) != 0, 1'($urandom));
      if ($urandom_range(0, 99) == 0) mid_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
